la_aoi21_bist: RTL and testbench
================================

# la_aoi21_bist

Self-test stage wrapped around one aoi21 cell instance. It drives the cell's a0/a1/b0 inputs with an exhaustive 8-vector sweep and consumes the cell's z output. It compares z against ~((a0&a1)|b0) and reports pass/fail, a saturating error count and the first failing vector. It is used in silicon characterization and production test of standard-cell rows, sitting between the test controller and the cell under test.

## Interface
- PASSES, default 1: number of full 8-vector sweeps per run; legal 1..255.
- SETTLE, default 1: cycles between applying a vector and sampling z; legal 1..15.
- PROP, default "DEFAULT": implementation property string, passed through and unused functionally.

Ports:
- clk  input  1  single clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin a run; sampled only in IDLE.
- abort  input  1  terminate a run immediately.
- a0  output  1  stimulus to cell under test.
- a1  output  1  stimulus to cell under test.
- b0  output  1  stimulus to cell under test.
- z  input  1  response from cell under test.
- busy  output  1  run in progress.
- done  output  1  sticky; last run completed normally.
- pass  output  1  valid when done=1; 1 means zero mismatches.
- errcnt  output  8  mismatch count, saturates at 255.
- failvalid  output  1  at least one mismatch captured.
- failvec  output  3  first failing vector {a0,a1,b0}.

## Operation
- Registered state: 3-bit vec counter, 8-bit pass counter, 4-bit settle counter.
- Stimulus: {a0,a1,b0} = vec, with a0 as the MSB. Outputs are registered. Stimulus is 3'b000 whenever busy=0.
- States:
  - IDLE
    - start=1 and abort=0: clear errcnt, failvalid, failvec, done and pass; set vec=0, pass counter=0, settle counter=SETTLE-1; go to SETTLE.
  - SETTLE
    - Hold vec. Decrement settle counter; at 0 go to SAMPLE.
  - SAMPLE
    - Compute expected = ~((a0&a1)|b0) from the registered stimulus.
    - If z != expected:
      - errcnt += 1, saturating at 255.
      - If failvalid=0: capture failvec=vec and set failvalid=1.
    - If vec != 7: vec += 1, reload settle counter, go to SETTLE.
    - If vec == 7 and pass counter == PASSES-1: go to IDLE; set done=1 and pass=(mismatch total == 0).
    - If vec == 7 otherwise: pass counter += 1, vec wraps to 0, go to SETTLE.
- pass must reflect the current sample, so a mismatch in the final SAMPLE yields pass=0.
- abort=1 in any state: go to IDLE; busy=0, done=0, pass=0, stimulus=0. errcnt, failvalid and failvec keep their values.
- start and abort in the same cycle: abort wins.
- start while busy: ignored.
- A new start clears done.

## Timing
- Reset values: a0=a1=b0=0, busy=0, done=0, pass=0, errcnt=0, failvalid=0, failvec=0. State is IDLE.
- Reset asserted mid-run forces these values asynchronously. No run resumes after reset is released.
- Start accepted at edge E0: busy=1 and vec0 appear after E0.
- Each vector holds for SETTLE cycles in SETTLE plus 1 cycle in SAMPLE. z is sampled at the edge that leaves SAMPLE.
- Total busy length = PASSES*8*(SETTLE+1) cycles.
- On the edge that ends the final SAMPLE: busy falls, done rises, pass becomes valid, and the stimulus returns to 0.
- errcnt, failvec and failvalid update on the SAMPLE edge where the mismatch is seen.
- A minimum of 1 IDLE cycle separates runs.

## Test plan
- Correct cell model, PASSES=1, SETTLE=1, one start pulse -> busy high for exactly 16 cycles; vectors 0..7 in order; done=1, pass=1, errcnt=0, failvalid=0.
- z stuck at 0 (PASSES=1) -> errcnt=3, failvec=3'b000, failvalid=1, pass=0.
- z stuck at 1 -> errcnt=5, failvec=3'b001, pass=0.
- z stuck at 0 with PASSES=2 -> errcnt=6 and busy for 32 cycles.
- z stuck at 1 with PASSES=100 -> errcnt saturates at 255, pass=0.
- abort after 5 cycles with z stuck at 0 -> busy=0 next cycle, done=0, stimulus=0, errcnt=1 retained.
- Second start during busy -> no restart; total busy remains 16 cycles.
- Reset asserted mid-run -> all outputs take reset values immediately. A following start runs a full clean sweep.

Source files
------------

// File: rtl/la_aoi21_bist.sv
// la_aoi21_bist: exhaustive 8-vector self-test around one aoi21 cell.
// Drives {a0,a1,b0} through 0..7 for PASSES sweeps, samples z after SETTLE
// cycles per vector, and reports pass/fail, a saturating error count and
// the first failing vector.
module la_aoi21_bist #(
  parameter int unsigned PASSES = 1,
  parameter int unsigned SETTLE = 1,
  parameter string       PROP   = "DEFAULT"
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  output logic       a0,
  output logic       a1,
  output logic       b0,
  input  logic       z,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] errcnt,
  output logic       failvalid,
  output logic [2:0] failvec
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE
  } state_t;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE - 1);
  localparam logic [7:0] LAST_PASS   = 8'(PASSES - 1);

  state_t     state_q,      state_d;
  logic [2:0] vec_q,        vec_d;
  logic [7:0] pass_cnt_q,   pass_cnt_d;
  logic [3:0] settle_cnt_q, settle_cnt_d;
  logic       busy_q,       busy_d;
  logic       done_q,       done_d;
  logic       pass_q,       pass_d;
  logic [7:0] errcnt_q,     errcnt_d;
  logic       failvalid_q,  failvalid_d;
  logic [2:0] failvec_q,    failvec_d;

  logic expected;
  logic mismatch;

  // Next-state logic: sweep sequencing, response compare, abort override.
  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    pass_cnt_d   = pass_cnt_q;
    settle_cnt_d = settle_cnt_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    errcnt_d     = errcnt_q;
    failvalid_d  = failvalid_q;
    failvec_d    = failvec_q;

    expected = ~((vec_q[2] & vec_q[1]) | vec_q[0]);
    mismatch = (z != expected);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          errcnt_d     = '0;
          failvalid_d  = 1'b0;
          failvec_d    = '0;
          done_d       = 1'b0;
          pass_d       = 1'b0;
          vec_d        = '0;
          pass_cnt_d   = '0;
          settle_cnt_d = SETTLE_INIT;
          busy_d       = 1'b1;
          state_d      = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (settle_cnt_q == '0) begin
          state_d = ST_SAMPLE;
        end else begin
          settle_cnt_d = settle_cnt_q - 4'd1;
        end
      end

      ST_SAMPLE: begin
        if (mismatch) begin
          if (errcnt_q != '1) begin
            errcnt_d = errcnt_q + 8'd1;
          end
          if (!failvalid_q) begin
            failvalid_d = 1'b1;
            failvec_d   = vec_q;
          end
        end
        if (vec_q != 3'd7) begin
          vec_d        = vec_q + 3'd1;
          settle_cnt_d = SETTLE_INIT;
          state_d      = ST_SETTLE;
        end else if (pass_cnt_q == LAST_PASS) begin
          // Final verdict includes the sample taken on this very edge.
          pass_d  = (errcnt_q == '0) && !mismatch;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          vec_d   = '0;
          state_d = ST_IDLE;
        end else begin
          pass_cnt_d   = pass_cnt_q + 8'd1;
          vec_d        = '0;
          settle_cnt_d = SETTLE_INIT;
          state_d      = ST_SETTLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Abort beats start and any in-flight sample; error capture is retained.
    if (abort) begin
      state_d      = ST_IDLE;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      pass_d       = 1'b0;
      vec_d        = '0;
      pass_cnt_d   = '0;
      settle_cnt_d = '0;
      errcnt_d     = errcnt_q;
      failvalid_d  = failvalid_q;
      failvec_d    = failvec_q;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      vec_q        <= '0;
      pass_cnt_q   <= '0;
      settle_cnt_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      errcnt_q     <= '0;
      failvalid_q  <= 1'b0;
      failvec_q    <= '0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      pass_cnt_q   <= pass_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      errcnt_q     <= errcnt_d;
      failvalid_q  <= failvalid_d;
      failvec_q    <= failvec_d;
    end
  end

  assign a0        = vec_q[2];
  assign a1        = vec_q[1];
  assign b0        = vec_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign errcnt    = errcnt_q;
  assign failvalid = failvalid_q;
  assign failvec   = failvec_q;

endmodule

// File: tb/tb_la_aoi21_bist.sv
// Testbench for la_aoi21_bist: three instances (PASSES/SETTLE = 1/1, 2/3,
// 100/1), each wired to an aoi21 cell model whose response is inverted on
// the vectors selected by a per-run fault mask.
module tb_la_aoi21_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [2:0] start, abort, z, a0, a1, b0, busy, done, pass, failvalid;
  logic [7:0] errcnt  [3];
  logic [2:0] failvec [3];
  logic [7:0] mask    [3];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  la_aoi21_bist #(.PASSES(1), .SETTLE(1)) u_dut0 (
    .clk(clk), .reset(reset), .start(start[0]), .abort(abort[0]),
    .a0(a0[0]), .a1(a1[0]), .b0(b0[0]), .z(z[0]), .busy(busy[0]),
    .done(done[0]), .pass(pass[0]), .errcnt(errcnt[0]),
    .failvalid(failvalid[0]), .failvec(failvec[0])
  );

  la_aoi21_bist #(.PASSES(2), .SETTLE(3)) u_dut1 (
    .clk(clk), .reset(reset), .start(start[1]), .abort(abort[1]),
    .a0(a0[1]), .a1(a1[1]), .b0(b0[1]), .z(z[1]), .busy(busy[1]),
    .done(done[1]), .pass(pass[1]), .errcnt(errcnt[1]),
    .failvalid(failvalid[1]), .failvec(failvec[1])
  );

  la_aoi21_bist #(.PASSES(100), .SETTLE(1)) u_dut2 (
    .clk(clk), .reset(reset), .start(start[2]), .abort(abort[2]),
    .a0(a0[2]), .a1(a1[2]), .b0(b0[2]), .z(z[2]), .busy(busy[2]),
    .done(done[2]), .pass(pass[2]), .errcnt(errcnt[2]),
    .failvalid(failvalid[2]), .failvec(failvec[2])
  );

  // Cell under test: aoi21 with optional per-vector inversion faults.
  always_comb begin
    z = '0;
    for (int i = 0; i < 3; i++) begin
      z[i] = ~((a0[i] & a1[i]) | b0[i]) ^ mask[i][{a0[i], a1[i], b0[i]}];
    end
  end

  localparam logic [7:0] STUCK0 = 8'b0001_0101;  // vectors where aoi21 = 1
  localparam logic [7:0] STUCK1 = 8'b1110_1010;  // vectors where aoi21 = 0

  function automatic int unsigned passes_of(int i);
    case (i)
      0:       return 1;
      1:       return 2;
      default: return 100;
    endcase
  endfunction

  function automatic int unsigned settle_of(int i);
    return (i == 1) ? 3 : 1;
  endfunction

  // Mismatches seen after n samples (vector j is sampled n-th as j mod 8).
  function automatic logic [7:0] exp_err(logic [7:0] m, int unsigned n);
    int unsigned c = 0;
    for (int unsigned j = 0; j < n; j++) if (m[j % 8]) c++;
    return (c > 255) ? 8'd255 : 8'(c);
  endfunction

  // {failvalid, failvec} after n samples.
  function automatic logic [3:0] exp_first(logic [7:0] m, int unsigned n);
    for (int unsigned j = 0; j < 8 && j < n; j++) if (m[j]) return {1'b1, 3'(j)};
    return 4'b0;
  endfunction

  // One full run from a start pulse; optional second start while busy.
  task automatic run_full(input int i, input logic [7:0] m, input int restart_at,
                          input string tag);
    int unsigned s1, total, n;
    logic [2:0] stim, want_vec;
    logic [3:0] ff;
    logic [7:0] ee;
    s1    = settle_of(i) + 1;
    total = passes_of(i) * 8 * s1;
    mask[i] = m;
    @(negedge clk); start[i] = 1'b1;
    @(negedge clk); start[i] = 1'b0;
    for (int k = 0; k <= int'(total); k++) begin
      if (k > 0) @(negedge clk);
      start[i] = (restart_at >= 0 && k == restart_at);
      stim = {a0[i], a1[i], b0[i]};
      n    = int'(k) / s1;
      ee   = exp_err(m, n);
      ff   = exp_first(m, n);
      if (k < int'(total)) begin
        want_vec = 3'(n % 8);
        n_checks++;
        if (busy[i] !== 1'b1) begin
          n_fail++; $display("FAIL %s busy@%0d got %b want 1", tag, k, busy[i]);
        end
        n_checks++;
        if (stim !== want_vec) begin
          n_fail++; $display("FAIL %s vec@%0d got %0d want %0d", tag, k, stim, want_vec);
        end
        n_checks++;
        if (errcnt[i] !== ee || failvalid[i] !== ff[3] || failvec[i] !== ff[2:0]) begin
          n_fail++;
          $display("FAIL %s capture@%0d got cnt=%0d fv=%b vec=%0d want cnt=%0d fv=%b vec=%0d",
                   tag, k, errcnt[i], failvalid[i], failvec[i], ee, ff[3], ff[2:0]);
        end
        if (k == 0) begin
          n_checks++;
          if (done[i] !== 1'b0 || pass[i] !== 1'b0) begin
            n_fail++; $display("FAIL %s start_clears got done=%b pass=%b want 0 0", tag, done[i], pass[i]);
          end
        end
      end else begin
        n_checks++;
        if (busy[i] !== 1'b0 || stim !== 3'b000) begin
          n_fail++; $display("FAIL %s end_idle got busy=%b stim=%0d want 0 0", tag, busy[i], stim);
        end
        n_checks++;
        if (done[i] !== 1'b1 || pass[i] !== (m == 8'h00)) begin
          n_fail++; $display("FAIL %s verdict got done=%b pass=%b want 1 %b", tag, done[i], pass[i], m == 8'h00);
        end
        n_checks++;
        if (errcnt[i] !== ee || failvalid[i] !== ff[3] || failvec[i] !== ff[2:0]) begin
          n_fail++;
          $display("FAIL %s final got cnt=%0d fv=%b vec=%0d want cnt=%0d fv=%b vec=%0d",
                   tag, errcnt[i], failvalid[i], failvec[i], ee, ff[3], ff[2:0]);
        end
      end
    end
    start[i] = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (done[i] !== 1'b1 || pass[i] !== (m == 8'h00) || busy[i] !== 1'b0) begin
      n_fail++; $display("FAIL %s sticky got done=%b pass=%b busy=%b want 1 %b 0", tag, done[i], pass[i], busy[i], m == 8'h00);
    end
  endtask

  // Abort asserted at negedge ak (takes effect at the following edge).
  task automatic run_abort(input int i, input logic [7:0] m, input int ak,
                           input bit collide, input string tag);
    int unsigned s1, n;
    logic [3:0] ff;
    logic [7:0] ee;
    s1 = settle_of(i) + 1;
    mask[i] = m;
    @(negedge clk); start[i] = 1'b1;
    @(negedge clk); start[i] = 1'b0;
    for (int k = 1; k <= ak; k++) @(negedge clk);
    abort[i] = 1'b1;
    @(negedge clk); abort[i] = 1'b0;
    n  = ak / s1;
    ee = exp_err(m, n);
    ff = exp_first(m, n);
    for (int r = 0; r < 2; r++) begin
      n_checks++;
      if (busy[i] !== 1'b0 || done[i] !== 1'b0 || pass[i] !== 1'b0 || {a0[i], a1[i], b0[i]} !== 3'b000) begin
        n_fail++; $display("FAIL %s aborted_idle[%0d] got busy=%b done=%b pass=%b stim=%0d want 0 0 0 0",
                           tag, r, busy[i], done[i], pass[i], {a0[i], a1[i], b0[i]});
      end
      n_checks++;
      if (errcnt[i] !== ee || failvalid[i] !== ff[3] || failvec[i] !== ff[2:0]) begin
        n_fail++;
        $display("FAIL %s retained[%0d] got cnt=%0d fv=%b vec=%0d want cnt=%0d fv=%b vec=%0d",
                 tag, r, errcnt[i], failvalid[i], failvec[i], ee, ff[3], ff[2:0]);
      end
      if (r == 0) @(negedge clk);
    end
    if (collide) begin
      start[i] = 1'b1; abort[i] = 1'b1;
      @(negedge clk); start[i] = 1'b0; abort[i] = 1'b0;
      @(negedge clk);
      n_checks++;
      if (busy[i] !== 1'b0 || errcnt[i] !== ee || failvalid[i] !== ff[3]) begin
        n_fail++; $display("FAIL %s abort_wins got busy=%b cnt=%0d fv=%b want 0 %0d %b",
                           tag, busy[i], errcnt[i], failvalid[i], ee, ff[3]);
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (busy[i] !== 1'b0 || done[i] !== 1'b0 || pass[i] !== 1'b0 || errcnt[i] !== 8'd0 ||
          failvalid[i] !== 1'b0 || failvec[i] !== 3'd0 || {a0[i], a1[i], b0[i]} !== 3'b000) begin
        n_fail++; $display("FAIL reset_values[%0d] got busy=%b done=%b pass=%b cnt=%0d fv=%b vec=%0d stim=%0d want all 0",
                           i, busy[i], done[i], pass[i], errcnt[i], failvalid[i], failvec[i], {a0[i], a1[i], b0[i]});
      end
    end
  endtask

  task automatic test_clean_sweep();       run_full(0, 8'h00, -1, "clean");      endtask
  task automatic test_stuck0();            run_full(0, STUCK0, -1, "stuck0");   endtask
  task automatic test_stuck1();            run_full(0, STUCK1, -1, "stuck1");   endtask
  task automatic test_two_passes();        run_full(1, STUCK0, -1, "two_pass"); endtask
  task automatic test_saturation();        run_full(2, STUCK1, -1, "saturate"); endtask
  task automatic test_start_while_busy();  run_full(0, 8'h00, 5, "restart");    endtask
  task automatic test_abort();             run_abort(0, STUCK0, 4, 1'b1, "abort"); endtask

  task automatic test_reset_mid_run();
    mask[0] = STUCK0;
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    repeat (6) @(negedge clk);
    #2 reset = 1'b1;
    #1 test_reset();
    @(negedge clk); reset = 1'b0;
    run_full(0, 8'h00, -1, "after_reset");
  endtask

  task automatic test_random();
    int unsigned tot;
    logic [7:0] m;
    for (int r = 0; r < 6; r++) begin
      int i = r % 2;
      m = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      tot = passes_of(i) * 8 * (settle_of(i) + 1);
      if (r % 3 == 2) run_abort(i, m, int'($urandom_range(0, tot - 2)), 1'b0, "rand_abort");
      else            run_full(i, m, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, tot - 2)) : -1, "rand_run");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = '0;
    abort = '0;
    for (int i = 0; i < 3; i++) mask[i] = 8'h00;
    repeat (2) @(negedge clk);
    test_reset();
    reset = 1'b0;
    test_clean_sweep();
    test_stuck0();
    test_stuck1();
    test_two_passes();
    test_saturation();
    test_abort();
    test_start_while_busy();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
